// File: rtl/spg_pkg.sv
// rtl/spg_pkg.sv - shared state type and default sizes for the spike-pair generator
package spg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } spg_state_t;

  localparam int SPG_NCH_DEF   = 2;
  localparam int SPG_CNT_W_DEF = 16;
  localparam int SPG_REP_W_DEF = 8;

endpackage

// File: rtl/spg_pulse_chan.sv
// rtl/spg_pulse_chan.sv - one spike line: width down-counter (pulse mode) or toggle flop
module spg_pulse_chan
  import spg_pkg::*;
#(
  parameter int CNT_W = SPG_CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic             i_event,
  input  logic             i_clear,
  input  logic             i_toggle,
  input  logic [CNT_W-1:0] i_width,
  output logic             o_out
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_out;

  // Toggle levels ignore clear so they survive DONE and stop; only reset drops them.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
      r_out <= 1'b0;
    end else if (i_toggle) begin
      if (i_en && i_event) begin
        r_out <= ~r_out;
      end
    end else if (i_clear) begin
      r_cnt <= '0;
      r_out <= 1'b0;
    end else if (i_en) begin
      if (i_event) begin
        r_cnt <= i_width;
        r_out <= (i_width != '0);
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
        r_out <= (r_cnt > CNT_W'(1));
      end else begin
        r_out <= 1'b0;
      end
    end
  end

  assign o_out = r_out;

endmodule

// File: rtl/spike_pair_gen.sv
// rtl/spike_pair_gen.sv - pre/post spike-pair sequencer; SPG_TOGGLE_EN adds toggle_mode
module spike_pair_gen
  import spg_pkg::*;
#(
  parameter int NCH   = SPG_NCH_DEF,
  parameter int CNT_W = SPG_CNT_W_DEF,
  parameter int REP_W = SPG_REP_W_DEF
) (
  input  logic                 clk_0_1ps,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 start,
  input  logic                 stop,
  input  logic [CNT_W-1:0]     cfg_period,
  input  logic [REP_W-1:0]     cfg_reps,
  input  logic [CNT_W-1:0]     cfg_width,
  input  logic [NCH*CNT_W-1:0] cfg_pre_off,
  input  logic [NCH*CNT_W-1:0] cfg_post_off,
`ifdef SPG_TOGGLE_EN
  input  logic                 toggle_mode,
`endif
  output logic [NCH-1:0]       tp,
  output logic [NCH-1:0]       td,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     phase,
  output logic [REP_W-1:0]     rep_cnt
);

  spg_state_t           r_state;
  logic [CNT_W-1:0]     r_phase;
  logic [REP_W-1:0]     r_rep_cnt;
  logic                 r_busy;
  logic                 r_done;
  logic [CNT_W-1:0]     r_period;
  logic [REP_W-1:0]     r_reps;
  logic [CNT_W-1:0]     r_width;
  logic [NCH*CNT_W-1:0] r_pre_off;
  logic [NCH*CNT_W-1:0] r_post_off;
  logic                 r_toggle;

  logic                 w_toggle_in;
  logic                 w_wrap;
  logic                 w_last;
  logic                 w_clear;
  logic                 w_live;
  logic [NCH-1:0]       w_pre_hit;
  logic [NCH-1:0]       w_post_hit;

`ifdef SPG_TOGGLE_EN
  assign w_toggle_in = toggle_mode;
`else
  assign w_toggle_in = 1'b0;
`endif

  assign w_wrap  = (r_phase == r_period - CNT_W'(1));
  assign w_last  = (r_rep_cnt == r_reps - REP_W'(1));
  assign w_clear = stop || ((r_state == DONE) && enable);
  assign w_live  = (r_state == RUN) && enable && !stop;

  always_ff @(posedge clk_0_1ps) begin
    if (reset) begin
      r_state    <= IDLE;
      r_phase    <= '0;
      r_rep_cnt  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_period   <= '0;
      r_reps     <= '0;
      r_width    <= '0;
      r_pre_off  <= '0;
      r_post_off <= '0;
      r_toggle   <= 1'b0;
    end else if (stop) begin
      r_state   <= IDLE;
      r_phase   <= '0;
      r_rep_cnt <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else if (enable) begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            // A zero period would never wrap; run it as a one-cycle period.
            r_period   <= (cfg_period == '0) ? CNT_W'(1) : cfg_period;
            r_reps     <= cfg_reps;
            r_width    <= cfg_width;
            r_pre_off  <= cfg_pre_off;
            r_post_off <= cfg_post_off;
            r_toggle   <= w_toggle_in;
            r_phase    <= '0;
            r_rep_cnt  <= '0;
            if (cfg_reps == '0) begin
              r_state <= DONE;
            end else begin
              r_state <= RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (w_wrap) begin
            r_phase   <= '0;
            r_rep_cnt <= r_rep_cnt + REP_W'(1);
            if (w_last) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_phase <= r_phase + CNT_W'(1);
          end
        end
        DONE: begin
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    assign w_pre_hit[c]  = w_live && (r_phase == r_pre_off[c*CNT_W +: CNT_W]);
    assign w_post_hit[c] = w_live && (r_phase == r_post_off[c*CNT_W +: CNT_W]);

    spg_pulse_chan #(.CNT_W(CNT_W)) u_tp (
      .i_clk    (clk_0_1ps),
      .i_reset  (reset),
      .i_en     (enable),
      .i_event  (w_pre_hit[c]),
      .i_clear  (w_clear),
      .i_toggle (r_toggle),
      .i_width  (r_width),
      .o_out    (tp[c])
    );

    spg_pulse_chan #(.CNT_W(CNT_W)) u_td (
      .i_clk    (clk_0_1ps),
      .i_reset  (reset),
      .i_en     (enable),
      .i_event  (w_post_hit[c]),
      .i_clear  (w_clear),
      .i_toggle (r_toggle),
      .i_width  (r_width),
      .o_out    (td[c])
    );
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign phase   = r_phase;
  assign rep_cnt = r_rep_cnt;

endmodule

// File: doc/spike_pair_gen.md
# spike_pair_gen

Parametrised, synthesizable pre/post spike-pair stimulus generator for the neuron/synapse datapath. Drives NCH independent channels of presynaptic (tp) and postsynaptic (td) spike lines with programmable per-channel offsets inside a repeating period, for a programmed repetition count. It replaces hand-timed tp1/td4 stimulus with a configurable on-chip sequencer that the top level can drive from `clk_0_1ps`.

## Interface
- NCH, 2, number of channels
- CNT_W, 16, width of period/offset/width counters
- REP_W, 8, width of repetition counter
- clk_0_1ps  in  1  single system clock; all logic rising-edge
- reset  in  1  synchronous, active-high
- enable  in  1  global advance; 0 freezes all counters and outputs
- start  in  1  one-cycle request; sampled only in IDLE with enable=1
- stop  in  1  synchronous abort
- cfg_period  in  CNT_W  cycles per repetition
- cfg_reps  in  REP_W  repetition count
- cfg_width  in  CNT_W  pulse width in cycles
- cfg_pre_off  in  NCH*CNT_W  per-channel tp phase offset, channel c at [c*CNT_W +: CNT_W]
- cfg_post_off  in  NCH*CNT_W  per-channel td phase offset, same packing
- tp  out  NCH  presynaptic spike lines
- td  out  NCH  postsynaptic spike lines
- busy  out  1  high in RUN
- done  out  1  one-cycle completion pulse
- phase  out  CNT_W  current phase
- rep_cnt  out  REP_W  completed repetitions

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `start` & `enable` latches all cfg_* into shadow registers; phase=0, rep_cnt=0; to RUN. If cfg_reps=0, to DONE instead. `start` in RUN/DONE ignored.
- RUN (with enable=1): phase increments each cycle; at phase=period-1, phase wraps to 0 and rep_cnt increments; when rep_cnt reaches reps-1 at that wrap, to DONE.
- cfg_period=0 treated as 1.
- Events: phase==pre_off[c] fires tp event c; phase==post_off[c] fires td event c; both may fire the same cycle. Offsets >= period never fire.
- Pulse mode: event loads a width down-counter; output high while counter non-zero. Retrigger reloads, so width >= period yields a continuous high. width=0 produces no pulse. Pulses may cross a period wrap.
- DONE: done=1 for one cycle, all pulse counters cleared, to IDLE.
- stop (any state, has priority over start): to IDLE, pulse outputs 0, no done.
- enable=0: state, phase, rep_cnt and pulse counters hold; outputs hold.
- Reset: state IDLE; tp=0, td=0, busy=0, done=0, phase=0, rep_cnt=0.

## Timing
- All outputs are registered.
- Start accepted at edge E0, giving RUN with phase 0 after E0.
- An event at offset k gives an output rise after edge E0+k+1; the pulse is high for cfg_width cycles.
- Final wrap occurs at edge E0+period·reps. done is high for the following cycle; busy falls at that same edge.
- Each cycle of enable=0 in RUN delays every later event and done by one cycle.
- Reset mid-run returns to IDLE at the same edge.

## Configuration
- SPG_TOGGLE_EN defined: adds input port `toggle_mode` (1 bit, sampled at start).
  - When toggle_mode=1, each event inverts tp[c]/td[c] and cfg_width is ignored.
  - Toggle levels persist through DONE, IDLE and stop; only reset clears them.
- Macro undefined: the port is absent and the block operates in pulse mode only.

## Structure
- Package spg_pkg: state enum spg_state_t (IDLE, RUN, DONE), default parameter constants.
- Sub-module spg_pulse_chan, instantiated 2·NCH times: event, enable, clear inputs; width counter or toggle flop; registered output.
- Top holds the FSM, phase/rep counters, shadow config and offset comparators.

## Test plan
All scenarios use NCH=2, CNT_W=16.
- Nominal run: period=100, reps=6, width=2; ch0 pre_off=0, post_off=10; ch1 pre_off=5, post_off=95.
  - tp[0] high cycles 1–2, td[0] high 11–12 after E0, repeating every 100.
  - td[1] high at 96–97 of each period.
  - done at cycle 601; tp/td low afterwards.
- reps=0 -> done one cycle after start; no tp/td activity; busy stays 0.
- enable low for 5 cycles starting at phase 50 of rep 2 -> all later edges shifted +5; done at cycle 606; phase holds 50 during the freeze.
- Abort and reset mid-run:
  - stop at rep 3, phase 10 -> outputs 0 and busy 0 on the next cycle; no done; a following start runs normally from phase 0.
  - reset mid-pulse -> all outputs 0 at the next edge.
- Boundary cases:
  - post_off=150 with period=100 -> td never asserts.
  - pre_off=post_off=20 -> tp and td rise in the same cycle.
  - width=150 with period=100 -> tp stays high continuously from its first rise until done.
- SPG_TOGGLE_EN, toggle_mode=1, reps=6, ch0 offsets 0/10 -> tp[0] and td[0] each toggle 6 times, ending at 0, and hold after done.
